// File: rtl/sfp_std2slf.sv
// IEEE754 single -> 26-bit self-defined float, 4-stage pipeline, one word per clock.
// Optional round-half-up is enabled with `define SFP_STD2SLF_RND_EN (truncation otherwise).
module sfp_std2slf (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic [31:0] i_dat,
  output logic        o_vld,
  output logic [25:0] o_dat
);

  logic [4:1] vld_pipe;

  // P1: unpack/classify
  logic        s1_sgn, s1_zero, s1_inf, s1_nan, s1_den;
  logic [7:0]  s1_exp;
  logic [23:0] s1_man;

  // P2: normalize count
  logic              s2_sgn, s2_kill, s2_inf;
  logic [23:0]       s2_man;
  logic [4:0]        s2_lz;
  logic signed [9:0] s2_ei;

  // P3: aligned magnitude and exponent
  logic        s3_sgn;
  logic [16:0] s3_m;
  logic [7:0]  s3_e;

  function automatic logic [4:0] lzc(input logic [23:0] v);
    lzc = 5'd0;
    for (int i = 0; i < 24; i++)
      if (v[i]) lzc = 5'(23 - i);
  endfunction

  logic [4:0]        lz_c;
  logic signed [9:0] ei_c;
  assign lz_c = lzc(s1_man);
  assign ei_c = s1_den ? (-10'sd126 - $signed({5'd0, lz_c}))
                       : ($signed({2'b00, s1_exp}) - 10'sd127);

  logic [23:0]       mn;
  logic signed [9:0] ea, sh;
  logic [16:0]       mq;
`ifdef SFP_STD2SLF_RND_EN
  logic [17:0]       sum;
`endif

  always_comb begin
    mn = s2_man << s2_lz;
    ea = s2_ei;
    sh = '0;
    // Below the format's exponent floor: denormalize into e = -128.
    if (s2_ei < -10'sd128) begin
      sh = -10'sd128 - s2_ei;
      mn = (sh > 10'sd23) ? 24'd0 : (mn >> sh[4:0]);
      ea = -10'sd128;
    end
`ifdef SFP_STD2SLF_RND_EN
    sum = {1'b0, mn[23:7]} + {17'd0, mn[6]};
    mq  = sum[16:0];
    if (sum[17]) begin
      mq = 17'h10000;
      ea = ea + 10'sd1;
    end
    if (ea == 10'sd128) begin
      mq = 17'h1FFFF;
      ea = 10'sd127;
    end
`else
    mq = mn[23:7];
`endif
    // Special classes override the arithmetic result.
    if (s2_inf) begin
      mq = 17'h1FFFF;
      ea = 10'sd127;
    end
    if (s2_kill) mq = 17'd0;
  end

  // P4: sign-apply and pack; a zero magnitude always packs to all-zero.
  logic [17:0] f_c;
  logic [25:0] dat_c;
  always_comb begin
    f_c   = s3_sgn ? (18'd0 - {1'b0, s3_m}) : {1'b0, s3_m};
    dat_c = (s3_m == 17'd0) ? 26'd0 : {f_c[17], s3_e, f_c[16:0]};
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      vld_pipe <= '0;
      s1_sgn <= 1'b0; s1_zero <= 1'b0; s1_inf <= 1'b0; s1_nan <= 1'b0; s1_den <= 1'b0;
      s1_exp <= '0;   s1_man  <= '0;
      s2_sgn <= 1'b0; s2_kill <= 1'b0; s2_inf <= 1'b0;
      s2_man <= '0;   s2_lz   <= '0;   s2_ei  <= '0;
      s3_sgn <= 1'b0; s3_m    <= '0;   s3_e   <= '0;
      o_dat  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[3:1], i_req};
      if (i_req) begin
        s1_sgn  <= i_dat[31];
        s1_exp  <= i_dat[30:23];
        s1_man  <= {i_dat[30:23] != 8'd0, i_dat[22:0]};
        s1_zero <= (i_dat[30:23] == 8'd0)   && (i_dat[22:0] == 23'd0);
        s1_inf  <= (i_dat[30:23] == 8'hFF)  && (i_dat[22:0] == 23'd0);
        s1_nan  <= (i_dat[30:23] == 8'hFF)  && (i_dat[22:0] != 23'd0);
        s1_den  <= (i_dat[30:23] == 8'd0)   && (i_dat[22:0] != 23'd0);
      end
      if (vld_pipe[1]) begin
        s2_sgn  <= s1_sgn;
        s2_man  <= s1_man;
        s2_lz   <= s1_den ? lz_c : 5'd0;
        s2_ei   <= ei_c;
        s2_kill <= s1_zero | s1_nan;
        s2_inf  <= s1_inf;
      end
      if (vld_pipe[2]) begin
        s3_sgn <= s2_sgn;
        s3_m   <= mq;
        s3_e   <= ea[7:0];
      end
      if (vld_pipe[3]) o_dat <= dat_c;
    end
  end

  assign o_vld = vld_pipe[4];

endmodule
